// File: rtl/barrel_scheduler.sv
// barrel_scheduler
//   Four-slot barrel scheduler. Each processed frame tick runs one pass:
//   MOVE advances every live barrel by one x step (retiring those already at
//   X_MAX) and may spawn a new barrel. The pass then walks the live slots in
//   ascending order through a shared collision checker.
//
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_tick                one-cycle frame enable
//   i_spawn_en, i_spawn_y spawn permission and y coordinate for a new barrel
//   i_game_over           level; blocks new passes while high
//   i_chk_done, i_chk_hit collision checker result strobe and result
//   o_chk_valid           request to the checker, o_chk_x/o_chk_y = barrel
//   o_active              slot-valid bits
//   o_barrel_x/_y         packed per-slot coordinates, slot 0 in the LSBs
//   o_hit_pulse           barrel retired on collision (one cycle)
//   o_dodge_pulse         barrel retired at X_MAX (one cycle)
//   o_busy                a pass is in progress
//   o_overrun             sticky, a tick was dropped
module barrel_scheduler #(
   parameter logic [7:0] SPAWN_X        = 8'd10,
   parameter logic [7:0] X_MAX          = 8'd150,
   parameter logic [3:0] SPAWN_INTERVAL = 4'd8
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_tick,
   input  logic        i_spawn_en,
   input  logic [6:0]  i_spawn_y,
   input  logic        i_game_over,
   input  logic        i_chk_done,
   input  logic        i_chk_hit,
   output logic        o_chk_valid,
   output logic [7:0]  o_chk_x,
   output logic [6:0]  o_chk_y,
   output logic [3:0]  o_active,
   output logic [31:0] o_barrel_x,
   output logic [27:0] o_barrel_y,
   output logic        o_hit_pulse,
   output logic        o_dodge_pulse,
   output logic        o_busy,
   output logic        o_overrun
);

   localparam int NUM_SLOTS = 4;

   typedef enum logic [1:0] {IDLE, MOVE, CHECK, NEXT} state_t;

   state_t                    r_state;
   logic [NUM_SLOTS-1:0]      r_active;
   logic [NUM_SLOTS-1:0][7:0] r_x;
   logic [NUM_SLOTS-1:0][6:0] r_y;
   logic [1:0]                r_idx;
   logic [3:0]                r_spawn_cnt;
   logic                      r_pending;
   logic                      r_overrun;
   logic                      r_chk_valid;
   logic                      r_hit_pulse;
   logic                      r_dodge_pulse;
   logic                      r_busy;

   // Lowest set bit of a slot mask as {found, index}.
   function automatic logic [2:0] first_set(input logic [NUM_SLOTS-1:0] mask);
      first_set = 3'b000;
      for (int i = NUM_SLOTS-1; i >= 0; i--)
         if (mask[i]) first_set = {1'b1, 2'(i)};
   endfunction

   logic [3:0]           w_spawn_cnt_inc;
   logic                 w_spawn_due;
   logic [2:0]           w_free;
   logic [NUM_SLOTS-1:0] w_dodge;
   logic [NUM_SLOTS-1:0] w_spawn_load;
   logic [NUM_SLOTS-1:0] w_active_mv;
   logic [2:0]           w_first_mv;
   logic [2:0]           w_first_next;

   always_comb begin
      w_spawn_cnt_inc = r_spawn_cnt + 4'd1;
      w_spawn_due     = (w_spawn_cnt_inc == SPAWN_INTERVAL);
      // Free slot is chosen from the pre-move mask, so a slot retiring in
      // this same MOVE is not reused until the next pass.
      w_free          = first_set(~r_active);
      w_spawn_load    = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         w_dodge[i] = r_active[i] && (r_x[i] == X_MAX);
         if (w_spawn_due && i_spawn_en && w_free[2] && (w_free[1:0] == 2'(i)))
            w_spawn_load[i] = 1'b1;
      end
      w_active_mv  = (r_active & ~w_dodge) | w_spawn_load;
      w_first_mv   = first_set(w_active_mv);
      // Slots strictly above the one just checked.
      w_first_next = first_set(r_active & (4'b1110 << r_idx));
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= IDLE;
         r_active      <= '0;
         r_x           <= '0;
         r_y           <= '0;
         r_idx         <= 2'd0;
         r_spawn_cnt   <= 4'd0;
         r_pending     <= 1'b0;
         r_overrun     <= 1'b0;
         r_chk_valid   <= 1'b0;
         r_hit_pulse   <= 1'b0;
         r_dodge_pulse <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_hit_pulse   <= 1'b0;
         r_dodge_pulse <= 1'b0;

         // Ticks arriving mid-pass queue one extra pass; a second one is lost.
         if (r_state != IDLE && i_tick) begin
            if (r_pending) r_overrun <= 1'b1;
            else           r_pending <= 1'b1;
         end

         case (r_state)
            IDLE: begin
               if (i_game_over) begin
                  r_pending <= 1'b0;
               end else if (i_tick || r_pending) begin
                  r_pending <= 1'b0;
                  r_state   <= MOVE;
                  r_busy    <= 1'b1;
               end
            end

            MOVE: begin
               for (int i = 0; i < NUM_SLOTS; i++) begin
                  if (w_spawn_load[i]) begin
                     r_x[i] <= SPAWN_X;
                     r_y[i] <= i_spawn_y;
                  end else if (r_active[i] && !w_dodge[i]) begin
                     r_x[i] <= r_x[i] + 8'd1;
                  end
               end
               r_active      <= w_active_mv;
               r_dodge_pulse <= |w_dodge;
               r_spawn_cnt   <= w_spawn_due ? 4'd0 : w_spawn_cnt_inc;
               if (w_first_mv[2]) begin
                  r_idx       <= w_first_mv[1:0];
                  r_state     <= CHECK;
                  r_chk_valid <= 1'b1;
               end else begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end

            CHECK: begin
               if (i_chk_done) begin
                  if (i_chk_hit) begin
                     r_active[r_idx] <= 1'b0;
                     r_hit_pulse     <= 1'b1;
                  end
                  r_state     <= NEXT;
                  r_chk_valid <= 1'b0;
               end
            end

            NEXT: begin
               if (w_first_next[2]) begin
                  r_idx       <= w_first_next[1:0];
                  r_state     <= CHECK;
                  r_chk_valid <= 1'b1;
               end else begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end

            default: begin
               r_state     <= IDLE;
               r_busy      <= 1'b0;
               r_chk_valid <= 1'b0;
            end
         endcase
      end
   end

   // Coordinates cannot change while a slot is under check, so a plain mux
   // of the slot registers keeps the request stable through the handshake.
   assign o_chk_valid   = r_chk_valid;
   assign o_chk_x       = r_x[r_idx];
   assign o_chk_y       = r_y[r_idx];
   assign o_active      = r_active;
   assign o_barrel_x    = r_x;
   assign o_barrel_y    = r_y;
   assign o_hit_pulse   = r_hit_pulse;
   assign o_dodge_pulse = r_dodge_pulse;
   assign o_busy        = r_busy;
   assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_barrel_scheduler.sv
// Directed bench for barrel_scheduler. Main instance uses SPAWN_INTERVAL=1;
// a second instance with SPAWN_INTERVAL=3 covers the spawn cadence.
module tb_barrel_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, tick, spawn_en, game_over, chk_done, chk_hit;
   logic [6:0]  spawn_y;
   logic        chk_valid, hit_pulse, dodge_pulse, busy, overrun;
   logic [7:0]  chk_x;
   logic [6:0]  chk_y;
   logic [3:0]  active;
   logic [31:0] bx;
   logic [27:0] by;

   logic        t2_tick, t2_done;
   logic        v2, hp2, dp2, busy2, ovr2;
   logic [7:0]  cx2;
   logic [6:0]  cy2;
   logic [3:0]  act2;
   logic [31:0] bx2;
   logic [27:0] by2;

   barrel_scheduler #(.SPAWN_X(8'd10), .X_MAX(8'd150), .SPAWN_INTERVAL(4'd1)) dut (
      .i_clk(clk), .i_reset(reset), .i_tick(tick), .i_spawn_en(spawn_en),
      .i_spawn_y(spawn_y), .i_game_over(game_over), .i_chk_done(chk_done),
      .i_chk_hit(chk_hit), .o_chk_valid(chk_valid), .o_chk_x(chk_x),
      .o_chk_y(chk_y), .o_active(active), .o_barrel_x(bx), .o_barrel_y(by),
      .o_hit_pulse(hit_pulse), .o_dodge_pulse(dodge_pulse), .o_busy(busy),
      .o_overrun(overrun));

   barrel_scheduler #(.SPAWN_X(8'd10), .X_MAX(8'd150), .SPAWN_INTERVAL(4'd3)) dut2 (
      .i_clk(clk), .i_reset(reset), .i_tick(t2_tick), .i_spawn_en(1'b1),
      .i_spawn_y(7'd33), .i_game_over(1'b0), .i_chk_done(t2_done),
      .i_chk_hit(1'b0), .o_chk_valid(v2), .o_chk_x(cx2), .o_chk_y(cy2),
      .o_active(act2), .o_barrel_x(bx2), .o_barrel_y(by2),
      .o_hit_pulse(hp2), .o_dodge_pulse(dp2), .o_busy(busy2), .o_overrun(ovr2));

   int cmp_n = 0;
   int fail_n = 0;

   // Results of the last run_pass.
   int         p_nchk, p_ndodge, p_nhit, p_unstable;
   logic       p_timeout;
   logic [7:0] p_ord_x [4];
   logic [6:0] p_ord_y [4];

   // One tick, then service every check request: the k-th check answers
   // hit_seq[k] after lat cycles of chk_valid. Returns once busy drops.
   task automatic run_pass(input logic [3:0] hit_seq, input int lat);
      int wait_c;
      logic [7:0] hx;
      logic [6:0] hy;
      wait_c = 0; hx = '0; hy = '0;
      p_nchk = 0; p_ndodge = 0; p_nhit = 0; p_unstable = 0; p_timeout = 1'b1;
      for (int k = 0; k < 4; k++) begin p_ord_x[k] = '0; p_ord_y[k] = '0; end
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      for (int c = 0; c < 60; c++) begin
         chk_done = 1'b0; chk_hit = 1'b0;
         if (dodge_pulse) p_ndodge++;
         if (hit_pulse)   p_nhit++;
         if (!busy) begin p_timeout = 1'b0; break; end
         if (chk_valid) begin
            if (wait_c == 0) begin
               if (p_nchk < 4) begin p_ord_x[p_nchk] = chk_x; p_ord_y[p_nchk] = chk_y; end
               hx = chk_x; hy = chk_y;
            end else if (chk_x !== hx || chk_y !== hy) begin
               p_unstable++;
            end
            if (wait_c == lat - 1) begin
               chk_done = 1'b1;
               chk_hit  = (p_nchk < 4) && hit_seq[p_nchk[1:0]];
               p_nchk++;
               wait_c = 0;
            end else begin
               wait_c++;
            end
         end
         @(negedge clk);
      end
      chk_done = 1'b0; chk_hit = 1'b0;
   endtask

   task automatic t2_pass();
      @(negedge clk); t2_tick = 1'b1;
      @(negedge clk); t2_tick = 1'b0;
      for (int c = 0; c < 10; c++) begin
         t2_done = v2;
         @(negedge clk);
      end
      t2_done = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      cmp_n++; if (active !== 4'b0 || bx !== 32'd0 || by !== 28'd0) begin
         fail_n++; $display("FAIL reset_slots: active=%b x=%h y=%h want 0", active, bx, by); end
      cmp_n++; if ({chk_valid, hit_pulse, dodge_pulse, busy, overrun} !== 5'b0) begin
         fail_n++; $display("FAIL reset_flags: got %b want 00000",
                            {chk_valid, hit_pulse, dodge_pulse, busy, overrun}); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_spawn();
      spawn_en = 1'b1; spawn_y = 7'd20;
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      cmp_n++; if (busy !== 1'b1 || chk_valid !== 1'b0 || active !== 4'b0) begin
         fail_n++; $display("FAIL spawn_move: busy=%b valid=%b active=%b want 1 0 0000",
                            busy, chk_valid, active); end
      @(negedge clk);
      cmp_n++; if (active !== 4'b0001 || bx[7:0] !== 8'd10 || by[6:0] !== 7'd20) begin
         fail_n++; $display("FAIL spawn_slot: active=%b x=%0d y=%0d want 0001 10 20",
                            active, bx[7:0], by[6:0]); end
      cmp_n++; if (chk_valid !== 1'b1 || chk_x !== 8'd10 || chk_y !== 7'd20) begin
         fail_n++; $display("FAIL spawn_chk: valid=%b x=%0d y=%0d want 1 10 20",
                            chk_valid, chk_x, chk_y); end
      chk_done = 1'b1; chk_hit = 1'b0; spawn_en = 1'b0;
      @(negedge clk); chk_done = 1'b0;
      cmp_n++; if (chk_valid !== 1'b0 || busy !== 1'b1) begin
         fail_n++; $display("FAIL spawn_next: valid=%b busy=%b want 0 1", chk_valid, busy); end
      @(negedge clk);
      cmp_n++; if (busy !== 1'b0 || active !== 4'b0001) begin
         fail_n++; $display("FAIL spawn_end: busy=%b active=%b want 0 0001", busy, active); end
   endtask

   task automatic test_dodge();
      for (int n = 0; n < 139; n++) run_pass(4'b0, 1);
      cmp_n++; if (bx[7:0] !== 8'd149 || active !== 4'b0001) begin
         fail_n++; $display("FAIL dodge_walk: x=%0d active=%b want 149 0001", bx[7:0], active); end
      run_pass(4'b0, 1);
      cmp_n++; if (p_nchk !== 1 || p_ord_x[0] !== 8'd150 || p_ndodge !== 0) begin
         fail_n++; $display("FAIL dodge_at_max: checks=%0d x=%0d dodges=%0d want 1 150 0",
                            p_nchk, p_ord_x[0], p_ndodge); end
      run_pass(4'b0, 1);
      cmp_n++; if (p_nchk !== 0 || p_ndodge !== 1 || active !== 4'b0 || p_timeout !== 1'b0) begin
         fail_n++; $display("FAIL dodge_retire: checks=%0d dodges=%0d active=%b to=%b want 0 1 0000 0",
                            p_nchk, p_ndodge, active, p_timeout); end
   endtask

   task automatic test_order();
      spawn_en = 1'b1;
      spawn_y = 7'd1; run_pass(4'b0, 1);
      spawn_y = 7'd2; run_pass(4'b0, 1);
      spawn_y = 7'd3; run_pass(4'b0010, 1);
      spawn_en = 1'b0;
      cmp_n++; if (p_nchk !== 3 || p_ord_x[0] !== 8'd12 || p_ord_x[1] !== 8'd11 || p_ord_x[2] !== 8'd10) begin
         fail_n++; $display("FAIL order_three: n=%0d x=%0d,%0d,%0d want 3 12,11,10",
                            p_nchk, p_ord_x[0], p_ord_x[1], p_ord_x[2]); end
      cmp_n++; if (active !== 4'b0101 || bx !== {8'd0, 8'd10, 8'd11, 8'd12} ||
                   by !== {7'd0, 7'd3, 7'd2, 7'd1}) begin
         fail_n++; $display("FAIL order_setup: active=%b x=%h y=%h want 0101 000a0b0c", active, bx, by); end
      run_pass(4'b0010, 3);
      cmp_n++; if (p_nchk !== 2 || p_ord_x[0] !== 8'd13 || p_ord_x[1] !== 8'd11 ||
                   p_ord_y[0] !== 7'd1 || p_ord_y[1] !== 7'd3) begin
         fail_n++; $display("FAIL order_seq: n=%0d x=%0d,%0d y=%0d,%0d want 2 13,11 1,3",
                            p_nchk, p_ord_x[0], p_ord_x[1], p_ord_y[0], p_ord_y[1]); end
      cmp_n++; if (p_nhit !== 1 || active !== 4'b0001 || p_unstable !== 0) begin
         fail_n++; $display("FAIL order_hit: hits=%0d active=%b unstable=%0d want 1 0001 0",
                            p_nhit, active, p_unstable); end
   endtask

   task automatic test_overrun();
      int n;
      @(negedge clk); tick = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); tick = 1'b0;
      cmp_n++; if (overrun !== 1'b1 || busy !== 1'b1) begin
         fail_n++; $display("FAIL overrun_set: overrun=%b busy=%b want 1 1", overrun, busy); end
      n = 0;
      for (int c = 0; c < 30; c++) begin
         chk_done = chk_valid; chk_hit = 1'b0;
         if (chk_valid) n++;
         @(negedge clk);
      end
      chk_done = 1'b0;
      cmp_n++; if (n !== 2 || bx[7:0] !== 8'd15 || busy !== 1'b0) begin
         fail_n++; $display("FAIL overrun_passes: checks=%0d x=%0d busy=%b want 2 15 0", n, bx[7:0], busy); end
      cmp_n++; if (overrun !== 1'b1) begin
         fail_n++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
   endtask

   task automatic test_full();
      spawn_en = 1'b1;
      spawn_y = 7'd4; run_pass(4'b0, 1);
      spawn_y = 7'd5; run_pass(4'b0, 1);
      spawn_y = 7'd6; run_pass(4'b0, 1);
      cmp_n++; if (active !== 4'b1111) begin
         fail_n++; $display("FAIL full_fill: active=%b want 1111", active); end
      spawn_y = 7'd7; run_pass(4'b0, 1);
      cmp_n++; if (active !== 4'b1111 || bx !== {8'd11, 8'd12, 8'd13, 8'd19} ||
                   by !== {7'd6, 7'd5, 7'd4, 7'd1}) begin
         fail_n++; $display("FAIL full_nospawn: active=%b x=%h y=%h want 1111 0b0c0d13", active, bx, by); end
      cmp_n++; if (p_nchk !== 4 || p_ord_x[0] !== 8'd19 || p_ord_x[3] !== 8'd11 || overrun !== 1'b1) begin
         fail_n++; $display("FAIL full_checks: n=%0d first=%0d last=%0d ovr=%b want 4 19 11 1",
                            p_nchk, p_ord_x[0], p_ord_x[3], overrun); end
      spawn_en = 1'b0;
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      @(negedge clk);
      cmp_n++; if (chk_valid !== 1'b1) begin
         fail_n++; $display("FAIL full_in_check: valid=%b want 1", chk_valid); end
      reset = 1'b1;
      @(negedge clk);
      cmp_n++; if (chk_valid !== 1'b0 || active !== 4'b0 || busy !== 1'b0 ||
                   overrun !== 1'b0 || bx !== 32'd0) begin
         fail_n++; $display("FAIL full_reset: valid=%b active=%b busy=%b ovr=%b x=%h want 0 0000 0 0 0",
                            chk_valid, active, busy, overrun, bx); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_game_over();
      int busy_n;
      spawn_en = 1'b1; spawn_y = 7'd9;
      run_pass(4'b0, 1);
      game_over = 1'b1;
      busy_n = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); tick = 1'b1;
         @(negedge clk); tick = 1'b0;
         if (busy) busy_n++;
         @(negedge clk);
         if (busy) busy_n++;
      end
      cmp_n++; if (busy_n !== 0 || active !== 4'b0001 || bx[7:0] !== 8'd10 || chk_valid !== 1'b0) begin
         fail_n++; $display("FAIL gameover_frozen: busy_cycles=%0d active=%b x=%0d want 0 0001 10",
                            busy_n, active, bx[7:0]); end
      game_over = 1'b0; spawn_en = 1'b0;
      run_pass(4'b0, 1);
      cmp_n++; if (p_nchk !== 1 || p_ord_x[0] !== 8'd11 || active !== 4'b0001) begin
         fail_n++; $display("FAIL gameover_resume: n=%0d x=%0d active=%b want 1 11 0001",
                            p_nchk, p_ord_x[0], active); end
   endtask

   task automatic test_chk_ignored();
      int hp;
      hp = 0;
      @(negedge clk); chk_done = 1'b1; chk_hit = 1'b1;
      repeat (3) begin @(negedge clk); if (hit_pulse) hp++; end
      chk_done = 1'b0; chk_hit = 1'b0;
      @(negedge clk); if (hit_pulse) hp++;
      cmp_n++; if (hp !== 0 || active !== 4'b0001 || busy !== 1'b0) begin
         fail_n++; $display("FAIL chk_ignored: pulses=%0d active=%b busy=%b want 0 0001 0", hp, active, busy); end
   endtask

   task automatic test_interval();
      t2_pass(); t2_pass();
      cmp_n++; if (act2 !== 4'b0000) begin
         fail_n++; $display("FAIL interval_early: active=%b want 0000", act2); end
      t2_pass();
      cmp_n++; if (act2 !== 4'b0001 || bx2[7:0] !== 8'd10 || by2[6:0] !== 7'd33) begin
         fail_n++; $display("FAIL interval_third: active=%b x=%0d y=%0d want 0001 10 33",
                            act2, bx2[7:0], by2[6:0]); end
      t2_pass(); t2_pass();
      cmp_n++; if (act2 !== 4'b0001 || bx2[7:0] !== 8'd12) begin
         fail_n++; $display("FAIL interval_gap: active=%b x=%0d want 0001 12", act2, bx2[7:0]); end
      t2_pass();
      cmp_n++; if (act2 !== 4'b0011 || bx2[15:0] !== {8'd10, 8'd13} || busy2 !== 1'b0) begin
         fail_n++; $display("FAIL interval_sixth: active=%b x=%h busy=%b want 0011 0a0d 0",
                            act2, bx2[15:0], busy2); end
   endtask

   initial begin
      reset = 1'b1; tick = 1'b0; spawn_en = 1'b0; spawn_y = '0; game_over = 1'b0;
      chk_done = 1'b0; chk_hit = 1'b0; t2_tick = 1'b0; t2_done = 1'b0;
      test_reset();
      test_interval();
      test_spawn();
      test_dodge();
      test_order();
      test_overrun();
      test_full();
      test_game_over();
      test_chk_ignored();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
      $finish;
   end

endmodule

// File: doc/barrel_scheduler.md
BARREL_SCHEDULER -- requirements
Module: barrel_scheduler

Interface
REQ-001 Parameter SPAWN_X, 8'd10, x coordinate loaded into a newly spawned barrel.
REQ-002 Parameter X_MAX, 8'd150, x coordinate at which a barrel is retired as dodged; SHALL satisfy X_MAX > SPAWN_X.
REQ-003 Parameter SPAWN_INTERVAL, 4'd8, processed ticks between spawn attempts; SHALL satisfy 1 <= SPAWN_INTERVAL <= 15.
REQ-004 Clk  in  1  single clock; all state changes on rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 tick  in  1  one-Clk-wide frame enable pulse.
REQ-007 spawn_en  in  1  1 = spawning permitted.
REQ-008 spawn_y  in  7  y coordinate captured into a barrel at spawn.
REQ-009 game_over  in  1  level; freezes scheduling while high.
REQ-010 chk_done  in  1  shared collision checker result strobe.
REQ-011 chk_hit  in  1  collision result, qualified by chk_done.
REQ-012 chk_valid  out  1  request to shared collision checker.
REQ-013 chk_x  out  8  x of barrel under check.
REQ-014 chk_y  out  7  y of barrel under check.
REQ-015 active  out  4  slot-valid bits, bit i = slot i.
REQ-016 barrel_x  out  32  slot i x at [8i+7:8i].
REQ-017 barrel_y  out  28  slot i y at [7i+6:7i].
REQ-018 hit_pulse  out  1  one-cycle pulse, barrel retired on collision.
REQ-019 dodge_pulse  out  1  one-cycle pulse, barrel retired at X_MAX.
REQ-020 busy  out  1  high whenever state is not IDLE.
REQ-021 overrun  out  1  sticky; a tick was dropped.

Function
REQ-022 FSM states SHALL be IDLE, MOVE, CHECK, NEXT.
REQ-023 IDLE: at an edge sampling (tick or pending) and !game_over, the FSM SHALL go to MOVE and clear pending.
REQ-024 MOVE lasts exactly one cycle; at its ending edge, each active slot with x == X_MAX SHALL clear active and set dodge_pulse for the next cycle; every other active slot SHALL increment x by 1.
REQ-025 MOVE spawn: the spawn counter SHALL increment once per MOVE; on reaching SPAWN_INTERVAL it SHALL reset to 0 and, if spawn_en, load the lowest-index free slot with x=SPAWN_X, y=spawn_y, active=1; a spawned barrel is not moved in that MOVE.
REQ-026 Spawn with no free slot SHALL be skipped silently; the counter still resets.
REQ-027 After MOVE, the slot index SHALL scan 0..3; the FSM SHALL enter CHECK for each active slot in ascending order, skipping inactive slots with no extra cycles, and SHALL return to IDLE when none remain.
REQ-028 CHECK: chk_valid=1; chk_x and chk_y SHALL hold that slot's coordinates, stable, until the edge that samples chk_done=1.
REQ-029 On chk_done with chk_hit=1, the slot SHALL clear active and hit_pulse SHALL assert for the next cycle; the FSM then goes to NEXT.
REQ-030 On chk_done with chk_hit=0, the FSM SHALL go to NEXT with no slot change.
REQ-031 NEXT lasts one cycle with chk_valid=0, then selects the next active slot or IDLE.
REQ-032 chk_done while chk_valid=0 SHALL be ignored.
REQ-033 A tick while busy SHALL set pending; a tick while pending is already set SHALL be dropped and set overrun.
REQ-034 While game_over is high in IDLE, ticks SHALL be ignored, pending SHALL clear, and no spawn or move occurs; an in-progress pass SHALL complete normally.
REQ-035 At most one dodge_pulse and at most one hit_pulse SHALL occur per slot per pass; pulses never exceed one cycle.

Reset
REQ-036 Reset SHALL force state=IDLE, active=0, all x/y=0, spawn counter=0, pending=0, overrun=0, and chk_valid, hit_pulse, dodge_pulse and busy to 0, overriding any in-progress handshake.

Verification
REQ-037 SPAWN_INTERVAL=1, spawn_en=1, spawn_y=20, one tick -> after MOVE, active=0001, slot0 x=10 y=20, then chk_valid with chk_x=10, chk_y=20.
REQ-038 Slot0 at x=149, tick, chk_hit=0 -> x=150; next tick -> active[0]=0, dodge_pulse one cycle, no CHECK for slot0.
REQ-039 Slots 0 and 2 active, chk_done after 3 cycles with chk_hit=1 for slot2 only -> checks in order 0 then 2; after slot2 is checked, active[2]=0 and hit_pulse for one cycle.
REQ-040 Two extra ticks during one busy pass -> one further pass runs; overrun=1 and stays 1 until Reset.
REQ-041 All 4 slots active with a spawn due -> no slot changes and the counter returns to 0; Reset asserted mid-CHECK -> chk_valid=0 and active=0 on the next cycle.
REQ-042 game_over=1 in IDLE, 5 ticks -> busy stays 0 and positions are unchanged; after game_over=0, the next tick resumes normally.
